// File: rtl/video_mixer_pkg.sv
// Shared register map, layer enable bit positions and priority encodings
// for the three-layer video mixer.
package video_mixer_pkg;

  localparam logic [2:0] REG_ENABLE   = 3'd0;
  localparam logic [2:0] REG_PRIORITY = 3'd1;
  localparam logic [2:0] REG_BG_R     = 3'd2;
  localparam logic [2:0] REG_BG_G     = 3'd3;
  localparam logic [2:0] REG_BG_B     = 3'd4;
  localparam logic [2:0] REG_FADE     = 3'd5;
  localparam logic [2:0] REG_FRAME    = 3'd6;
  localparam logic [2:0] REG_STATUS   = 3'd7;

  localparam int EN_CHAR    = 0;
  localparam int EN_SPRITE  = 1;
  localparam int EN_TILEMAP = 2;

  typedef enum logic {
    PRIO_CHAR_FIRST   = 1'b0,
    PRIO_SPRITE_FIRST = 1'b1
  } prio_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [2:0] en;
    prio_e      prio;
    rgb_t       bg;
    logic [2:0] fade;
  } regs_t;

  localparam regs_t REGS_RESET = '{en: 3'b111, prio: PRIO_CHAR_FIRST, bg: '0, fade: 3'd0};

endpackage

// File: rtl/video_mixer_fade.sv
// One colour channel of the output stage: scales by (8 - fade)/8 and
// blanks to zero, with a registered result.
module video_mixer_fade (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] c_i,
  input  logic [2:0] fade_i,
  input  logic       blank_i,
  output logic [7:0] c_o
);

  logic [3:0]  scale;
  logic [10:0] prod;
  logic [7:0]  c_d;
  logic [7:0]  c_q;

  assign scale = 4'd8 - {1'b0, fade_i};
  assign prod  = {3'b000, c_i} * {7'b0000000, scale};
  assign c_d   = blank_i ? 8'd0 : prod[10:3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) c_q <= 8'd0;
    else          c_q <= c_d;
  end

  assign c_o = c_q;

endmodule

// File: rtl/video_mixer.sv
// Three-layer priority video mixer with CPU-visible shadow registers that
// take effect at the start of vertical blanking, plus a fade stage.
module video_mixer
  import video_mixer_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hblank,
  input  logic       vblank,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [7:0] char_r,
  input  logic [7:0] char_g,
  input  logic [7:0] char_b,
  input  logic       char_a,
  input  logic [7:0] sprite_r,
  input  logic [7:0] sprite_g,
  input  logic [7:0] sprite_b,
  input  logic       sprite_a,
  input  logic [7:0] tilemap_r,
  input  logic [7:0] tilemap_g,
  input  logic [7:0] tilemap_b,
  input  logic       tilemap_a,
  input  logic [2:0] addr,
  input  logic [7:0] data_in,
  input  logic       write,
  output logic [7:0] data_out,
  output logic [7:0] out_r,
  output logic [7:0] out_g,
  output logic [7:0] out_b,
  output logic       out_hblank,
  output logic       out_vblank,
  output logic       out_hsync,
  output logic       out_vsync
);

  regs_t      shadow_q, shadow_d;
  regs_t      active_q, active_d;
  logic [7:0] frame_q, frame_d;
  logic       vblank_last_q;
  logic       latch;
  rgb_t       col_p1_q, col_p1_d;
  logic [3:0] tim_p1_q, tim_p2_q;
  logic       char_ok, sprite_ok, tile_ok;

  // A write landing on the latch cycle is folded into shadow_d, so it is latched too.
  always_comb begin
    shadow_d = shadow_q;
    if (write) begin
      case (addr)
        REG_ENABLE:   shadow_d.en   = data_in[2:0];
        REG_PRIORITY: shadow_d.prio = prio_e'(data_in[0]);
        REG_BG_R:     shadow_d.bg.r = data_in;
        REG_BG_G:     shadow_d.bg.g = data_in;
        REG_BG_B:     shadow_d.bg.b = data_in;
        REG_FADE:     shadow_d.fade = data_in[2:0];
        default:      ;
      endcase
    end
  end

  assign latch    = vblank & ~vblank_last_q;
  assign active_d = latch ? shadow_d : active_q;
  assign frame_d  = frame_q + {7'd0, latch};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q      <= REGS_RESET;
      active_q      <= REGS_RESET;
      frame_q       <= 8'd0;
      vblank_last_q <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      frame_q       <= frame_d;
      vblank_last_q <= vblank;
    end
  end

  always_comb begin
    case (addr)
      REG_ENABLE:   data_out = {5'd0, shadow_q.en};
      REG_PRIORITY: data_out = {7'd0, shadow_q.prio};
      REG_BG_R:     data_out = shadow_q.bg.r;
      REG_BG_G:     data_out = shadow_q.bg.g;
      REG_BG_B:     data_out = shadow_q.bg.b;
      REG_FADE:     data_out = {5'd0, shadow_q.fade};
      REG_FRAME:    data_out = frame_q;
      REG_STATUS:   data_out = {6'd0, (shadow_q != active_q), vblank};
    endcase
  end

  assign char_ok   = active_q.en[EN_CHAR]    & char_a;
  assign sprite_ok = active_q.en[EN_SPRITE]  & sprite_a;
  assign tile_ok   = active_q.en[EN_TILEMAP] & tilemap_a;

  always_comb begin
    col_p1_d = active_q.bg;
    if (tile_ok)
      col_p1_d = '{r: tilemap_r, g: tilemap_g, b: tilemap_b};
    if (active_q.prio == PRIO_SPRITE_FIRST) begin
      if (char_ok)   col_p1_d = '{r: char_r, g: char_g, b: char_b};
      if (sprite_ok) col_p1_d = '{r: sprite_r, g: sprite_g, b: sprite_b};
    end else begin
      if (sprite_ok) col_p1_d = '{r: sprite_r, g: sprite_g, b: sprite_b};
      if (char_ok)   col_p1_d = '{r: char_r, g: char_g, b: char_b};
    end
  end

  // Stage 1: selected colour and timing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_p1_q <= '0;
      tim_p1_q <= 4'd0;
      tim_p2_q <= 4'd0;
    end else begin
      col_p1_q <= col_p1_d;
      tim_p1_q <= {hblank, vblank, hsync, vsync};
      tim_p2_q <= tim_p1_q;
    end
  end

  // Stage 2: fade and blanking, registered inside each channel scaler
  video_mixer_fade u_fade_r (
    .clk(clk), .reset_n(reset_n), .c_i(col_p1_q.r), .fade_i(active_q.fade),
    .blank_i(tim_p1_q[3] | tim_p1_q[2]), .c_o(out_r)
  );
  video_mixer_fade u_fade_g (
    .clk(clk), .reset_n(reset_n), .c_i(col_p1_q.g), .fade_i(active_q.fade),
    .blank_i(tim_p1_q[3] | tim_p1_q[2]), .c_o(out_g)
  );
  video_mixer_fade u_fade_b (
    .clk(clk), .reset_n(reset_n), .c_i(col_p1_q.b), .fade_i(active_q.fade),
    .blank_i(tim_p1_q[3] | tim_p1_q[2]), .c_o(out_b)
  );

  assign {out_hblank, out_vblank, out_hsync, out_vsync} = tim_p2_q;

endmodule

// File: tb/tb_video_mixer.sv
// Randomized and directed bench for video_mixer against a frame-level
// reference model of registers, layer priority and fade.
module tb_video_mixer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       hblank, vblank, hsync, vsync;
  logic [7:0] char_r, char_g, char_b, sprite_r, sprite_g, sprite_b;
  logic [7:0] tilemap_r, tilemap_g, tilemap_b;
  logic       char_a, sprite_a, tilemap_a;
  logic [2:0] addr;
  logic [7:0] data_in;
  logic       write;
  logic [7:0] data_out, out_r, out_g, out_b;
  logic       out_hblank, out_vblank, out_hsync, out_vsync;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: registers 0..5 as plain integers.
  int         m_sh[6];
  int         m_act[6];
  int         m_frame;
  bit         m_vbl;
  logic [23:0] m_col1, m_out;
  logic [3:0]  m_tim1, m_tout;
  int         mask[6] = '{7, 1, 255, 255, 255, 7};

  always #5 clk = ~clk;

  video_mixer dut (
    .clk(clk), .reset_n(reset_n),
    .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
    .char_r(char_r), .char_g(char_g), .char_b(char_b), .char_a(char_a),
    .sprite_r(sprite_r), .sprite_g(sprite_g), .sprite_b(sprite_b), .sprite_a(sprite_a),
    .tilemap_r(tilemap_r), .tilemap_g(tilemap_g), .tilemap_b(tilemap_b), .tilemap_a(tilemap_a),
    .addr(addr), .data_in(data_in), .write(write), .data_out(data_out),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_hblank(out_hblank), .out_vblank(out_vblank), .out_hsync(out_hsync), .out_vsync(out_vsync)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] fade_ch(input logic [7:0] c, input int f);
    return 8'((int'(c) * (8 - f)) / 8);
  endfunction

  function automatic logic [23:0] pick();
    logic [23:0] col[3];
    bit          a[3];
    int          ord[3];
    col[0] = {char_r, char_g, char_b};
    col[1] = {sprite_r, sprite_g, sprite_b};
    col[2] = {tilemap_r, tilemap_g, tilemap_b};
    a[0] = char_a; a[1] = sprite_a; a[2] = tilemap_a;
    if (m_act[1] == 1) ord = '{1, 0, 2};
    else               ord = '{0, 1, 2};
    for (int i = 0; i < 3; i++)
      if (((m_act[0] >> ord[i]) & 1) == 1 && a[ord[i]]) return col[ord[i]];
    return {8'(m_act[2]), 8'(m_act[3]), 8'(m_act[4])};
  endfunction

  function automatic logic [7:0] model_reg(input logic [2:0] a);
    bit dirty;
    dirty = 1'b0;
    for (int i = 0; i < 6; i++) if (m_sh[i] != m_act[i]) dirty = 1'b1;
    if (a < 3'd6) return 8'(m_sh[a]);
    if (a == 3'd6) return 8'(m_frame);
    return {6'd0, dirty, vblank};
  endfunction

  task automatic model_reset();
    m_sh  = '{7, 0, 0, 0, 0, 0};
    m_act = '{7, 0, 0, 0, 0, 0};
    m_frame = 0;
    m_vbl  = 1'b0;
    m_col1 = '0;
    m_tim1 = '0;
  endtask

  // Advance one clock: predict, clock, then compare outputs and register read.
  task automatic step();
    if (m_tim1[3] || m_tim1[2]) m_out = 24'd0;
    else m_out = {fade_ch(m_col1[23:16], m_act[5]), fade_ch(m_col1[15:8], m_act[5]),
                  fade_ch(m_col1[7:0], m_act[5])};
    m_tout = m_tim1;
    m_col1 = pick();
    m_tim1 = {hblank, vblank, hsync, vsync};
    if (write && addr < 3'd6) m_sh[addr] = int'(data_in) & mask[addr];
    if (vblank && !m_vbl) begin
      m_act = m_sh;
      m_frame = (m_frame + 1) % 256;
    end
    m_vbl = vblank;
    @(posedge clk); #1;
    check_eq("pix", {out_r, out_g, out_b}, m_out);
    check_eq("tim", {out_hblank, out_vblank, out_hsync, out_vsync}, m_tout);
    check_eq("dout", data_out, model_reg(addr));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    addr = a; data_in = d; write = 1'b1;
    step();
    write = 1'b0;
  endtask

  task automatic pulse_vblank();
    vblank = 1'b1; step();
    vblank = 1'b0; step();
  endtask

  task automatic do_reset();
    write = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_pix", {out_r, out_g, out_b}, 24'd0);
    check_eq("rst_tim", {out_hblank, out_vblank, out_hsync, out_vsync}, 4'd0);
    addr = 3'd0; #1;
    check_eq("rst_enable", data_out, 8'h07);
    addr = 3'd6; #1;
    check_eq("rst_frame", data_out, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_layers(input logic [23:0] c, input logic ca, input logic [23:0] s,
                            input logic sa, input logic [23:0] t, input logic ta);
    {char_r, char_g, char_b} = c; char_a = ca;
    {sprite_r, sprite_g, sprite_b} = s; sprite_a = sa;
    {tilemap_r, tilemap_g, tilemap_b} = t; tilemap_a = ta;
  endtask

  initial begin
    reset_n = 1'b1;
    {hblank, vblank, hsync, vsync} = 4'b0110;
    set_layers(24'h123456, 1'b1, 24'h789abc, 1'b1, 24'hdef012, 1'b1);
    addr = 3'd0; data_in = 8'd0; write = 1'b0;
    #7;
    do_reset();
    {hblank, vblank, hsync, vsync} = 4'b0000;

    // Layer priority
    set_layers({8'd10, 8'd20, 8'd30}, 1'b1, {8'd40, 8'd50, 8'd60}, 1'b1, 24'h0, 1'b0);
    steps(3);
    check_eq("prio0", {out_r, out_g, out_b}, {8'd10, 8'd20, 8'd30});
    cpu_write(3'd1, 8'd1);
    steps(2);
    check_eq("prio_before_latch", {out_r, out_g, out_b}, {8'd10, 8'd20, 8'd30});
    pulse_vblank();
    steps(2);
    check_eq("prio1", {out_r, out_g, out_b}, {8'd40, 8'd50, 8'd60});

    // Background and enable
    cpu_write(3'd2, 8'h11); cpu_write(3'd3, 8'h22); cpu_write(3'd4, 8'h33);
    char_a = 1'b0; sprite_a = 1'b0; tilemap_a = 1'b0;
    pulse_vblank(); steps(2);
    check_eq("bg_no_alpha", {out_r, out_g, out_b}, 24'h112233);
    cpu_write(3'd0, 8'd0);
    char_a = 1'b1; sprite_a = 1'b1; tilemap_a = 1'b1;
    pulse_vblank(); steps(2);
    check_eq("bg_disabled", {out_r, out_g, out_b}, 24'h112233);

    // Fade
    cpu_write(3'd0, 8'd7);
    set_layers(24'h0, 1'b0, 24'h0, 1'b0, {8'd255, 8'd128, 8'd8}, 1'b1);
    cpu_write(3'd5, 8'd4);
    pulse_vblank(); steps(2);
    check_eq("fade4", {out_r, out_g, out_b}, {8'd127, 8'd64, 8'd4});
    cpu_write(3'd5, 8'd7);
    pulse_vblank(); steps(2);
    check_eq("fade7", {out_r, out_g, out_b}, {8'd31, 8'd16, 8'd1});

    // Shadow versus active
    cpu_write(3'd5, 8'd3);
    addr = 3'd7; steps(2);
    check_eq("status_dirty", data_out, 8'h02);
    check_eq("fade_unlatched", {out_r, out_g, out_b}, {8'd31, 8'd16, 8'd1});
    pulse_vblank(); steps(2);
    check_eq("fade3", {out_r, out_g, out_b}, {8'd159, 8'd80, 8'd5});
    check_eq("status_clean", data_out, 8'h00);
    vblank = 1'b1; addr = 3'd5; data_in = 8'd0; write = 1'b1;
    step();
    write = 1'b0; vblank = 1'b0;
    step(); addr = 3'd7; steps(2);
    check_eq("latch_cycle_write", {out_r, out_g, out_b}, {8'd255, 8'd128, 8'd8});
    check_eq("latch_cycle_status", data_out, 8'h00);

    // Blanking delay
    hblank = 1'b1; step();
    check_eq("hblank_d1", out_hblank, 1'b0);
    step();
    check_eq("hblank_d2", out_hblank, 1'b1);
    hblank = 1'b0; step();
    check_eq("hblank_pix", {out_r, out_g, out_b}, 24'd0);
    steps(2);

    // Frame counter wrap
    do_reset();
    addr = 3'd6;
    for (int i = 0; i < 256; i++) pulse_vblank();
    check_eq("frame_wrap", data_out, 8'h00);
    pulse_vblank();
    check_eq("frame_one", data_out, 8'h01);

    // Random traffic, with a reset in the middle of a line
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      {char_r, char_g, char_b} = 24'($urandom);
      {sprite_r, sprite_g, sprite_b} = 24'($urandom);
      {tilemap_r, tilemap_g, tilemap_b} = 24'($urandom);
      char_a = 1'($urandom); sprite_a = 1'($urandom); tilemap_a = 1'($urandom);
      hblank = ($urandom_range(0, 7) == 0);
      hsync = 1'($urandom); vsync = 1'($urandom);
      if ($urandom_range(0, 15) == 0) vblank = ~vblank;
      write = ($urandom_range(0, 3) == 0);
      addr = 3'($urandom);
      data_in = 8'($urandom);
      step();
    end
    write = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
